// File: rtl/seg_pipe_adder_pkg.sv
// seg_pipe_adder_pkg: shared sizing helper and flag bundle for the segmented adder
package seg_pipe_adder_pkg;

   function automatic int calc_nseg(input int width, input int seg);
      return width / seg;
   endfunction

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
   } flags_t;

endpackage

// File: rtl/seg_ripple_add.sv
// seg_ripple_add: combinational SEG-bit ripple adder built from full-adder cells
module seg_ripple_add
   import seg_pipe_adder_pkg::*;
#(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a_i,
   input  logic [SEG-1:0] b_i,
   input  logic           c_i,
   output logic [SEG-1:0] s_o,
   output logic           c_o
);

   logic [SEG:0] c;

   assign c[0] = c_i;
   assign c_o  = c[SEG];

   for (genvar i = 0; i < SEG; i++) begin : g_fa
      assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

endmodule

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: pipelined add/sub resolving one SEG-bit segment per stage, valid/ready with global stall
module seg_pipe_adder
   import seg_pipe_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   input  logic             SUB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT,
   output logic             OVF,
   output logic             ZERO
);

   localparam int NSEG = calc_nseg(WIDTH, SEG);

   if (WIDTH % SEG != 0) begin : g_bad_seg
      $error("seg_pipe_adder: WIDTH must be a multiple of SEG");
   end

   logic             adv;
   logic [WIDTH-1:0] a_in [NSEG];
   logic [WIDTH-1:0] b_in [NSEG];
   logic [WIDTH-1:0] s_in [NSEG];
   logic             c_in [NSEG];
   logic             v_in [NSEG];
   logic             out_valid_q;
   logic [WIDTH-1:0] sum_q;
   flags_t           flags_q;

   // the whole pipe moves together; only a held result blocks it
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   // stage 0 sees the conditioned operands directly; subtraction is A + ~B + 1 with the borrow folded into the carry
   assign a_in[0] = A;
   assign b_in[0] = SUB ? ~B : B;
   assign c_in[0] = CIN ^ SUB;
   assign s_in[0] = '0;
   assign v_in[0] = in_valid;

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      logic [SEG-1:0]   seg_s;
      logic             seg_c;
      logic [WIDTH-1:0] s_d;

      seg_ripple_add #(.SEG(SEG)) u_add (
         .a_i(a_in[k][k*SEG +: SEG]),
         .b_i(b_in[k][k*SEG +: SEG]),
         .c_i(c_in[k]),
         .s_o(seg_s),
         .c_o(seg_c)
      );

      // splice this stage's segment into the partial sum carried by the token
      always_comb begin
         s_d = s_in[k];
         s_d[k*SEG +: SEG] = seg_s;
      end

      if (k < NSEG - 1) begin : g_mid
         logic             v_q;
         logic             c_q;
         logic [WIDTH-1:0] a_q;
         logic [WIDTH-1:0] b_q;
         logic [WIDTH-1:0] s_q;

         // shift the token one stage; datapath only loads for real tokens so idle operands leave no trace
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_q <= 1'b0;
               c_q <= 1'b0;
               a_q <= '0;
               b_q <= '0;
               s_q <= '0;
            end else if (adv) begin
               v_q <= v_in[k];
               if (v_in[k]) begin
                  c_q <= seg_c;
                  a_q <= a_in[k];
                  b_q <= b_in[k];
                  s_q <= s_d;
               end
            end
         end

         assign a_in[k+1] = a_q;
         assign b_in[k+1] = b_q;
         assign c_in[k+1] = c_q;
         assign s_in[k+1] = s_q;
         assign v_in[k+1] = v_q;
      end else begin : g_last
         flags_t flags_d;

         // flags derive from the completed sum and the operand sign bits
         always_comb begin
            flags_d      = '0;
            flags_d.cout = seg_c;
            flags_d.ovf  = (a_in[k][WIDTH-1] == b_in[k][WIDTH-1]) && (s_d[WIDTH-1] != a_in[k][WIDTH-1]);
            flags_d.zero = ~|s_d;
         end

         // result register; holds SUM and flags steady while the consumer stalls
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_valid_q <= 1'b0;
               sum_q       <= '0;
               flags_q     <= '0;
            end else if (adv) begin
               out_valid_q <= v_in[k];
               if (v_in[k]) begin
                  sum_q   <= s_d;
                  flags_q <= flags_d;
               end
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign SUM       = sum_q;
   assign COUT      = flags_q.cout;
   assign OVF       = flags_q.ovf;
   assign ZERO      = flags_q.zero;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// tb_seg_pipe_adder: random and directed checks of the segmented adder against an arithmetic model
module tb_seg_pipe_adder;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;

   logic         v8_in;
   logic         r8_in;
   logic [7:0]   a8;
   logic [7:0]   b8;
   logic         v8_out;
   logic [7:0]   s8;
   logic         c8;
   logic         o8;
   logic         z8;

   int   checks;
   int   errors;
   int   n_in;
   int   n_out;
   exp_t q[$];

   seg_pipe_adder #(.WIDTH(32), .SEG(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .CIN(cin), .SUB(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .SUM(sum), .COUT(cout), .OVF(ovf), .ZERO(zero)
   );

   seg_pipe_adder #(.WIDTH(8), .SEG(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8_in), .in_ready(r8_in),
      .A(a8), .B(b8), .CIN(1'b0), .SUB(1'b0),
      .out_valid(v8_out), .out_ready(1'b1),
      .SUM(s8), .COUT(c8), .OVF(o8), .ZERO(z8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // true-integer reference: signed range test for overflow, unsigned compare for carry/no-borrow
   function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input logic is);
      exp_t   r;
      longint sa = $signed(ia);
      longint sb = $signed(ib);
      longint ua = {32'b0, ia};
      longint ub = {32'b0, ib};
      longint ci = {63'b0, ic};
      longint full;
      longint ures;
      if (is) begin
         full   = sa - sb - ci;
         ures   = ua - ub - ci;
         r.cout = ua >= ub + ci;
      end else begin
         full   = sa + sb + ci;
         ures   = ua + ub + ci;
         r.cout = ures >= 64'sd4294967296;
      end
      r.sum  = ures[W-1:0];
      r.ovf  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      r.zero = r.sum == '0;
      return r;
   endfunction

   // scoreboard: predicts transfers at the coming edge from inputs that are stable since the last edge
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         chk("in_ready_rule", {63'b0, in_ready}, {63'b0, !out_valid || out_ready});
         if (q.size() == 0) begin
            chk("out_valid_without_token", {63'b0, out_valid}, 64'd0);
         end else if (out_valid) begin
            chk("stream_sum", {32'b0, sum}, {32'b0, q[0].sum});
            chk("stream_flags", {61'b0, cout, ovf, zero}, {61'b0, q[0].cout, q[0].ovf, q[0].zero});
            if (out_ready) begin
               void'(q.pop_front());
               n_out++;
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, sub));
            n_in++;
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input logic is,
                        input logic [W-1:0] es, input logic ec, input logic eo, input logic ez, input string nm);
      int n;
      in_valid  = 1'b1;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub       = is;
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
         cycle();
         n++;
      end
      chk({nm, "_latency"}, 64'(n), 64'd4);
      chk({nm, "_sum"}, {32'b0, sum}, {32'b0, es});
      chk({nm, "_cout"}, {63'b0, cout}, {63'b0, ec});
      chk({nm, "_ovf"}, {63'b0, ovf}, {63'b0, eo});
      chk({nm, "_zero"}, {63'b0, zero}, {63'b0, ez});
      cycle();
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int           c;
      int           k;
      int           n0;
      int           o0;
      logic [W-1:0] hold;
      checks    = 0;
      errors    = 0;
      n_in      = 0;
      n_out     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      v8_in     = 1'b0;
      a8        = '0;
      b8        = '0;
      #1;
      chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
      chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
      chk("reset_sum_flags", {29'b0, sum, cout, ovf, zero}, 64'd0);
      chk("reset8_out_valid", {63'b0, v8_out}, 64'd0);
      #21;
      rst_n = 1'b1;
      cycle();

      do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "carry_chain");
      do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "ovf_add");
      do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "ovf_sub");
      do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub_borrow");
      do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, "sub_borrow_cin");
      do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "carry_from_cin");

      n0 = n_in;
      o0 = n_out;
      c  = 0;
      hold = '0;
      while (n_in - n0 < 16 && c < 100) begin
         in_valid  = 1'b1;
         a         = $urandom;
         b         = $urandom;
         cin       = 1'($urandom);
         sub       = 1'($urandom);
         out_ready = !(c >= 8 && c < 11);
         #1;
         if (c == 8) begin
            chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
            chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
            hold = sum;
         end
         if (c == 9 || c == 10) chk("stall_sum_stable", {32'b0, sum}, {32'b0, hold});
         @(posedge clk);
         #1;
         c++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      k = 0;
      while (q.size() != 0 && k < 50) begin
         cycle();
         k++;
      end
      cycle();
      chk("stream_drained", 64'(q.size()), 64'd0);
      chk("stream_accepted", 64'(n_in - n0), 64'd16);
      chk("stream_delivered", 64'(n_out - o0), 64'd16);

      for (int i = 0; i < 400; i++) begin
         in_valid  = $urandom_range(0, 3) != 0;
         a         = pick();
         b         = pick();
         cin       = 1'($urandom);
         sub       = 1'($urandom);
         out_ready = $urandom_range(0, 3) != 0;
         cycle();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      k = 0;
      while (q.size() != 0 && k < 50) begin
         cycle();
         k++;
      end
      chk("random_drained", 64'(q.size()), 64'd0);

      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = 32'h1234_5678;
      b         = 32'h1111_1111;
      cin       = 1'b0;
      sub       = 1'b0;
      cycle();
      a = 32'h0000_0003;
      b = 32'h0000_0004;
      cycle();
      in_valid = 1'b0;
      cycle();
      cycle();
      chk("rst_pre_out_valid", {63'b0, out_valid}, 64'd1);
      chk("rst_pre_sum", {32'b0, sum}, 64'h2345_6789);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_async_sum", {32'b0, sum}, 64'd0);
      chk("rst_async_in_ready", {63'b0, in_ready}, 64'd1);
      #4;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("rst_no_ghost", {63'b0, out_valid}, 64'd0);
      end
      chk("rst_after_in_ready", {63'b0, in_ready}, 64'd1);

      v8_in = 1'b1;
      a8    = 8'h80;
      b8    = 8'h80;
      cycle();
      v8_in = 1'b0;
      chk("deg_out_valid", {63'b0, v8_out}, 64'd1);
      chk("deg_sum", {56'b0, s8}, 64'd0);
      chk("deg_flags", {61'b0, c8, o8, z8}, 64'd7);
      chk("deg_in_ready", {63'b0, r8_in}, 64'd1);
      cycle();
      chk("deg_drained", {63'b0, v8_out}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
